// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: game-level sequencer for the frog datapath.
// Runs the IDLE/PLAY/DYING/LEVEL_UP/OVER state machine, turns held keycodes
// into one-shot step commands, issues respawn pulses and tracks lives, level
// and the per-life countdown.
// Build option: define FROG_TIMER_EN to enable the countdown timer and the
// timeout death. Without it, time_left is loaded on reload and then holds.

module frog_game_ctrl #(
    parameter int LIVES_INIT     = 3,
    parameter int GOAL_Y         = 137,
    parameter int TIMER_INIT     = 30,
    parameter int FRAMES_PER_SEC = 60,
    parameter int DEATH_FRAMES   = 60,
    parameter int WIN_FRAMES     = 90
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    input  logic        collision,
    input  logic [9:0]  frog_y,
    output logic        step_up,
    output logic        step_down,
    output logic        step_left,
    output logic        step_right,
    output logic        respawn,
    output logic [2:0]  lives,
    output logic [3:0]  level,
    output logic [5:0]  time_left,
    output logic [2:0]  state,
    output logic        game_over
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAY     = 3'd1,
        S_DYING    = 3'd2,
        S_LEVEL_UP = 3'd3,
        S_OVER     = 3'd4
    } state_t;

    localparam logic [15:0] KEY_W     = 16'h001A;
    localparam logic [15:0] KEY_A     = 16'h0004;
    localparam logic [15:0] KEY_S     = 16'h0016;
    localparam logic [15:0] KEY_D     = 16'h0007;
    localparam logic [15:0] KEY_SPACE = 16'h002C;

    localparam int MAX_FRAMES = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0] DEATH_LOAD = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD   = CNT_W'(WIN_FRAMES - 1);
    localparam logic [2:0]       LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [5:0]       TIME_LOAD  = 6'(TIMER_INIT);
    localparam logic [9:0]       GOAL_LINE  = 10'(GOAL_Y);

    state_t           r_state;
    logic [15:0]      r_prev_key;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_step_up;
    logic             r_step_down;
    logic             r_step_left;
    logic             r_step_right;
    logic             r_respawn;
    logic [2:0]       r_lives;
    logic [3:0]       r_level;
    logic [5:0]       r_time_left;
    logic             r_game_over;

    logic w_is_w;
    logic w_is_a;
    logic w_is_s;
    logic w_is_d;
    logic w_is_space;
    logic w_new_press;
    logic w_space_press;
    logic w_goal;
    logic w_timeout;
    logic w_death;
    logic w_reload;

    assign w_is_w        = (keycode == KEY_W);
    assign w_is_a        = (keycode == KEY_A);
    assign w_is_s        = (keycode == KEY_S);
    assign w_is_d        = (keycode == KEY_D);
    assign w_is_space    = (keycode == KEY_SPACE);
    assign w_new_press   = (keycode != r_prev_key) &&
                           (w_is_w || w_is_a || w_is_s || w_is_d || w_is_space);
    assign w_space_press = w_new_press && w_is_space;
    assign w_goal        = (frog_y <= GOAL_LINE);
    assign w_death       = (r_state == S_PLAY) && (collision || w_timeout);

    // A timer reload happens on every entry into PLAY (game start or end of a freeze)
    assign w_reload = ((r_state == S_IDLE)     && w_space_press) ||
                      ((r_state == S_DYING)    && (r_frame_cnt == '0) && (r_lives != 3'd0)) ||
                      ((r_state == S_LEVEL_UP) && (r_frame_cnt == '0));

    // Remember last frame's keycode so a held key yields only one press
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) r_prev_key <= 16'h0000;
        else       r_prev_key <= keycode;
    end

`ifdef FROG_TIMER_EN
    localparam int               SUB_W   = $clog2(FRAMES_PER_SEC + 1);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(FRAMES_PER_SEC - 1);

    logic [SUB_W-1:0] r_sub_cnt;
    logic             w_tick;

    assign w_timeout = (r_state == S_PLAY) && (r_time_left == 6'd0);
    assign w_tick    = (r_state == S_PLAY) && !collision && !w_timeout && !w_goal;

    // Per-life countdown: frames roll into seconds only while play continues
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_time_left <= 6'd0;
            r_sub_cnt   <= '0;
        end else if (w_reload) begin
            r_time_left <= TIME_LOAD;
            r_sub_cnt   <= '0;
        end else if (w_tick) begin
            if (r_sub_cnt == SUB_MAX) begin
                r_sub_cnt <= '0;
                if (r_time_left != 6'd0) r_time_left <= r_time_left - 6'd1;
            end else begin
                r_sub_cnt <= r_sub_cnt + SUB_W'(1);
            end
        end
    end
`else
    assign w_timeout = 1'b0;

    // Without the countdown the displayed time is just the reload value
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)         r_time_left <= 6'd0;
        else if (w_reload) r_time_left <= TIME_LOAD;
    end
`endif

    // Game state machine with registered pulses, lives, level and game-over flag
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_frame_cnt  <= '0;
            r_step_up    <= 1'b0;
            r_step_down  <= 1'b0;
            r_step_left  <= 1'b0;
            r_step_right <= 1'b0;
            r_respawn    <= 1'b0;
            r_lives      <= 3'd0;
            r_level      <= 4'd0;
            r_game_over  <= 1'b0;
        end else begin
            r_step_up    <= 1'b0;
            r_step_down  <= 1'b0;
            r_step_left  <= 1'b0;
            r_step_right <= 1'b0;
            r_respawn    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_space_press) begin
                        r_state   <= S_PLAY;
                        r_lives   <= LIVES_LOAD;
                        r_level   <= 4'd1;
                        r_respawn <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (w_death) begin
                        if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
                        r_frame_cnt <= DEATH_LOAD;
                        r_state     <= S_DYING;
                    end else if (w_goal) begin
                        if (r_level != 4'd15) r_level <= r_level + 4'd1;
                        r_frame_cnt <= WIN_LOAD;
                        r_state     <= S_LEVEL_UP;
                    end else if (w_new_press) begin
                        r_step_up    <= w_is_w;
                        r_step_down  <= w_is_s;
                        r_step_left  <= w_is_a;
                        r_step_right <= w_is_d;
                    end
                end
                S_DYING: begin
                    if (r_frame_cnt == '0) begin
                        if (r_lives == 3'd0) begin
                            r_state     <= S_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state   <= S_PLAY;
                            r_respawn <= 1'b1;
                        end
                    end else begin
                        r_frame_cnt <= r_frame_cnt - CNT_W'(1);
                    end
                end
                S_LEVEL_UP: begin
                    if (r_frame_cnt == '0) begin
                        r_state   <= S_PLAY;
                        r_respawn <= 1'b1;
                    end else begin
                        r_frame_cnt <= r_frame_cnt - CNT_W'(1);
                    end
                end
                S_OVER: begin
                    if (w_space_press) begin
                        r_state     <= S_IDLE;
                        r_game_over <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign step_up    = r_step_up;
    assign step_down  = r_step_down;
    assign step_left  = r_step_left;
    assign step_right = r_step_right;
    assign respawn    = r_respawn;
    assign lives      = r_lives;
    assign level      = r_level;
    assign time_left  = r_time_left;
    assign state      = r_state;
    assign game_over  = r_game_over;

endmodule
